uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter: alternating-priority arbiter feeding an 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 86
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       serialOutput,
    output logic [1:0] grant,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             last_q, last_d;
    logic             line_q, line_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic [1:0]       grant_q, grant_d;
    logic             busy_q, busy_d;

    logic             bit_end;
    logic             win;
    logic [2:0]       idx_nxt;

    assign bit_end = (cnt_q == CNT_LAST);
    assign idx_nxt = idx_q + 3'd1;
    // On a tie the requester that lost the previous acceptance wins.
    assign win     = (req0 && req1) ? ~last_q : req1;

    // State and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= 8'h00;
            last_q  <= 1'b1;
            line_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            line_q  <= line_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    // Next state plus next output values, so every output leaves a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        last_d  = last_q;
        line_d  = line_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        grant_d = grant_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                line_d  = 1'b1;
                busy_d  = 1'b0;
                grant_d = 2'b00;
                cnt_d   = '0;
                idx_d   = '0;
                if (req0 || req1) begin
                    state_d = S_START;
                    shift_d = win ? data1 : data0;
                    last_d  = win;
                    ack0_d  = ~win;
                    ack1_d  = win;
                    grant_d = {win, ~win};
                    line_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                    line_d  = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        line_d  = ^shift_q;
`else
                        state_d = S_STOP;
                        line_d  = 1'b1;
`endif
                    end else begin
                        idx_d  = idx_nxt;
                        line_d = shift_q[idx_nxt];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    line_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    line_d  = 1'b1;
                    busy_d  = 1'b0;
                    grant_d = 2'b00;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                line_d  = 1'b1;
                busy_d  = 1'b0;
                grant_d = 2'b00;
            end
        endcase
    end

    assign serialOutput = line_q;
    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign grant        = grant_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter against a frame-level reference model.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_arbiter;

    localparam int CPB = 86;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rstN;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       ack0, ack1;
    logic       serialOutput;
    logic [1:0] grant;
    logic       busy;

    int   total = 0;
    int   bad   = 0;
    logic mlast;

    uart_tx_arbiter #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .req0        (req0),
        .data0       (data0),
        .ack0        (ack0),
        .req1        (req1),
        .data1       (data1),
        .ack1        (ack1),
        .serialOutput(serialOutput),
        .grant       (grant),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line levels of one frame, index 0 sent first.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    // Predict the winner from current requests, then follow one whole frame.
    task automatic do_frame(input bit keep, input bit add_other);
        logic        w;
        logic [7:0]  b;
        logic [10:0] f;
        logic [1:0]  g;
        logic        obs;
        int          n, xack, xgnt, xbusy;
        w = (req0 && req1) ? ~mlast : req1;
        b = w ? data1 : data0;
        mlast = w;
        f = frame_of(b);
        g = w ? 2'b10 : 2'b01;
        n = 0;
        while (!(ack0 || ack1) && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'd1);
        chk("ack", 32'({ack1, ack0}), 32'(g));
        chk("grant", 32'(grant), 32'(g));
        chk("busy_on", 32'(busy), 32'd1);
        if (!keep) begin
            if (w) req1 = 1'b0;
            else   req0 = 1'b0;
        end
        xack = 0;
        xgnt = 0;
        xbusy = 0;
        for (int k = 0; k < NBITS; k++) begin
            obs = f[k];
            for (int j = 0; j < CPB; j++) begin
                if (serialOutput !== f[k]) obs = serialOutput;
                if ((k != 0 || j != 0) && (ack0 || ack1)) xack++;
                if (grant !== g) xgnt++;
                if (busy !== 1'b1) xbusy++;
                if (k == 3 && j == 0 && !keep) begin
                    if (w) data1 = 8'h00;
                    else   data0 = 8'h00;
                end
                if (k == 4 && j == 0 && add_other) begin
                    if (w && !req0) begin
                        req0 = 1'b1;
                        data0 = 8'($urandom);
                    end else if (!w && !req1) begin
                        req1 = 1'b1;
                        data1 = 8'($urandom);
                    end
                end
                @(negedge clk);
            end
            chk($sformatf("bit%0d_%02h", k, b), 32'(obs), 32'(f[k]));
        end
        chk("extra_ack", 32'(xack), 32'd0);
        chk("grant_hold", 32'(xgnt), 32'd0);
        chk("busy_hold", 32'(xbusy), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_line", 32'(serialOutput), 32'd1);
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_ack", 32'({ack1, ack0}), 32'd0);
    endtask

    initial begin
        int n, lows, acks, busys;
        rstN  = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = 8'h00;
        data1 = 8'h00;
        mlast = 1'b1;
        #12;
        chk("rst_line", 32'(serialOutput), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'({ack1, ack0}), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        req0 = 1'b1;
        data0 = 8'hAF;
        do_frame(1'b0, 1'b0);

        for (int r = 0; r < 2; r++) begin
            req0 = 1'b1;
            data0 = 8'h55;
            req1 = 1'b1;
            data1 = 8'hA5;
            do_frame(1'b0, 1'b0);
            do_frame(1'b0, 1'b0);
        end

        req1 = 1'b1;
        data1 = 8'h3C;
        do_frame(1'b1, 1'b0);
        do_frame(1'b1, 1'b0);
        do_frame(1'b0, 1'b0);

        req0 = 1'b1;
        data0 = 8'hF0;
        do_frame(1'b0, 1'b0);

        for (int t = 0; t < 16; t++) begin
            if (!req0 && !req1) begin
                n = int'($urandom_range(1, 3));
                if (n[0]) begin
                    req0 = 1'b1;
                    data0 = 8'($urandom);
                end
                if (n[1]) begin
                    req1 = 1'b1;
                    data1 = 8'($urandom);
                end
            end
            do_frame($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end
        req0 = 1'b0;
        req1 = 1'b0;

        @(negedge clk);
        req0 = 1'b1;
        data0 = 8'($urandom) & 8'hF7;
        n = 0;
        while (!ack0 && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("rst_frame_ack", 32'(ack0), 32'd1);
        req0 = 1'b0;
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        chk("pre_rst_line", 32'(serialOutput), 32'd0);
        #2 rstN = 1'b0;
        #1;
        chk("async_line", 32'(serialOutput), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_grant", 32'(grant), 32'd0);
        mlast = 1'b1;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        lows = 0;
        acks = 0;
        busys = 0;
        for (int c = 0; c < 3 * CPB; c++) begin
            @(negedge clk);
            if (serialOutput !== 1'b1) lows++;
            if (ack0 || ack1) acks++;
            if (busy !== 1'b0) busys++;
        end
        chk("post_rst_low", 32'(lows), 32'd0);
        chk("post_rst_ack", 32'(acks), 32'd0);
        chk("post_rst_busy", 32'(busys), 32'd0);

        req0 = 1'b1;
        data0 = 8'($urandom);
        req1 = 1'b1;
        data1 = 8'($urandom);
        do_frame(1'b0, 1'b0);
        do_frame(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
